// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the fetch PC, drives the instruction SRAM read
// port and applies branch / flush redirects, buffering branches seen under stall.
module if_stage #(
    parameter int unsigned FS_TO_DS_BUS_WD = 32,
    parameter logic [31:0] RESET_PC        = 32'h1c00_0000
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic [31:0]                new_pc,
    input  logic [5:0]                 stall,
    input  logic                       br_taken,
    input  logic [31:0]                br_target,
    output logic                       inst_sram_en,
    output logic [3:0]                 inst_sram_we,
    output logic [31:0]                inst_sram_addr,
    output logic [31:0]                inst_sram_wdata,
    output logic                       pc_valid,
    output logic [FS_TO_DS_BUS_WD-1:0] fs_to_ds_bus,
    output logic [31:0]                csr_vec_h
);

    localparam int unsigned PC_W = 32;

    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [PC_W-1:0] pc_r;
    logic [PC_W-1:0] pc_next;
    logic            pend_v;
    logic            pend_v_next;
    logic [PC_W-1:0] pend_target;
    logic [PC_W-1:0] pend_target_next;

    logic            if_stall;
    logic            run;
    logic            adef;
    logic [PC_W-1:0] pc_out;

    // Only the IF bit of the per-stage stall vector matters here.
    logic            stall_unused;
    assign stall_unused = |stall[5:1];
    assign if_stall     = stall[0];

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= BOOT;
        end else begin
            state <= state_next;
        end
    end

    // PC and pending-branch registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_r        <= RESET_PC;
            pend_v      <= 1'b0;
            pend_target <= '0;
        end else begin
            pc_r        <= pc_next;
            pend_v      <= pend_v_next;
            pend_target <= pend_target_next;
        end
    end

    // Next-state and next-PC selection; flush outranks stall, stall outranks branches.
    always_comb begin
        state_next       = state;
        pc_next          = pc_r;
        pend_v_next      = pend_v;
        pend_target_next = pend_target;
        unique case (state)
            BOOT: begin
                // First fetch is RESET_PC itself, so the PC is not advanced here.
                if (flush) begin
                    state_next  = RUN;
                    pc_next     = new_pc;
                    pend_v_next = 1'b0;
                end else if (!if_stall) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (flush) begin
                    pc_next     = new_pc;
                    pend_v_next = 1'b0;
                end else if (if_stall) begin
                    if (br_taken) begin
                        pend_v_next      = 1'b1;
                        pend_target_next = br_target;
                    end
                end else if (br_taken) begin
                    pc_next     = br_target;
                    pend_v_next = 1'b0;
                end else if (pend_v) begin
                    pc_next     = pend_target;
                    pend_v_next = 1'b0;
                end else begin
                    pc_next = pc_r + PC_W'(4);
                end
            end
            default: begin
                state_next = BOOT;
            end
        endcase
    end

    // Outputs decode from state; reset forces the quiet boot view immediately.
    always_comb begin
        run    = (state == RUN) && !reset;
        pc_out = reset ? RESET_PC : pc_r;
        adef   = run && (pc_out[1:0] != 2'b00);

        pc_valid        = run;
        csr_vec_h       = {31'b0, adef};
        inst_sram_en    = run && !adef;
        inst_sram_addr  = pc_out;
        inst_sram_we    = 4'b0;
        inst_sram_wdata = 32'b0;
        fs_to_ds_bus    = FS_TO_DS_BUS_WD'(pc_out);
    end

endmodule

// File: tb/tb_if_stage.sv
// Scoreboard bench for if_stage: each step drives one cycle of inputs, queues the
// required post-edge outputs, and the scenario task pops and compares them.
module tb_if_stage;

    localparam logic [31:0] RST_PC = 32'h1c00_0000;

    logic        clk;
    logic        reset;
    logic        flush;
    logic [31:0] new_pc;
    logic [5:0]  stall;
    logic        br_taken;
    logic [31:0] br_target;
    logic        inst_sram_en;
    logic [3:0]  inst_sram_we;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_wdata;
    logic        pc_valid;
    logic [31:0] fs_to_ds_bus;
    logic [31:0] csr_vec_h;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic        rst;
        logic        fl;
        logic [31:0] npc;
        logic        st;
        logic        br;
        logic [31:0] bt;
        logic        v;
        logic [31:0] a;
        string       nm;
    } step_t;

    typedef struct {
        string       nm;
        logic [97:0] val;
    } exp_t;

    exp_t sb[$];

    if_stage #(
        .FS_TO_DS_BUS_WD(32),
        .RESET_PC       (RST_PC)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .flush          (flush),
        .new_pc         (new_pc),
        .stall          (stall),
        .br_taken       (br_taken),
        .br_target      (br_target),
        .inst_sram_en   (inst_sram_en),
        .inst_sram_we   (inst_sram_we),
        .inst_sram_addr (inst_sram_addr),
        .inst_sram_wdata(inst_sram_wdata),
        .pc_valid       (pc_valid),
        .fs_to_ds_bus   (fs_to_ds_bus),
        .csr_vec_h      (csr_vec_h)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic step_t mk(input logic rst, input logic fl, input logic [31:0] npc,
                                 input logic st, input logic br, input logic [31:0] bt,
                                 input logic v, input logic [31:0] a, input string nm);
        step_t s;
        s.rst = rst; s.fl = fl; s.npc = npc; s.st = st;
        s.br  = br;  s.bt = bt; s.v   = v;   s.a  = a;  s.nm = nm;
        return s;
    endfunction

    // Drive one cycle of inputs and queue the outputs required after the next edge.
    task automatic drive_step(input step_t s);
        exp_t  e;
        logic  mis;
        reset     = s.rst;
        flush     = s.fl;
        new_pc    = s.npc;
        stall     = {5'b0, s.st};
        br_taken  = s.br;
        br_target = s.bt;
        mis   = s.v && (s.a[1:0] != 2'b00);
        e.nm  = s.nm;
        e.val = {s.v, s.v && !mis, {31'b0, mis}, s.a, s.a};
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [97:0] observe();
        return {pc_valid, inst_sram_en, csr_vec_h, inst_sram_addr, fs_to_ds_bus};
    endfunction

    task automatic test_reset();
        step_t s[$];
        exp_t  e;
        logic [97:0] obs;
        s.push_back(mk(1, 0, 0, 0, 0, 0, 0, RST_PC, "reset_c0"));
        s.push_back(mk(1, 0, 0, 0, 0, 0, 0, RST_PC, "reset_c1"));
        s.push_back(mk(1, 0, 0, 0, 0, 0, 0, RST_PC, "reset_c2"));
        foreach (s[i]) begin
            drive_step(s[i]);
            tick();
            e = sb.pop_front();
            obs = observe();
            checks++;
            if (obs !== e.val) begin
                failures++;
                $display("FAIL %s got=%h exp=%h", e.nm, obs, e.val);
            end
        end
        // First cycle after release is still BOOT: nothing valid, write port idle.
        reset = 1'b0;
        #1;
        checks++;
        if ({pc_valid, inst_sram_en, inst_sram_we, inst_sram_wdata} !== 38'h0) begin
            failures++;
            $display("FAIL boot_after_release got=%b/%b/%h/%h exp=0/0/0/0",
                     pc_valid, inst_sram_en, inst_sram_we, inst_sram_wdata);
        end
        s.delete();
        s.push_back(mk(0, 0, 0, 0, 0, 0, 1, 32'h1c00_0000, "first_fetch"));
        s.push_back(mk(0, 0, 0, 0, 0, 0, 1, 32'h1c00_0004, "seq_04"));
        s.push_back(mk(0, 0, 0, 0, 0, 0, 1, 32'h1c00_0008, "seq_08"));
        foreach (s[i]) begin
            drive_step(s[i]);
            tick();
            e = sb.pop_front();
            obs = observe();
            checks++;
            if (obs !== e.val) begin
                failures++;
                $display("FAIL %s got=%h exp=%h", e.nm, obs, e.val);
            end
        end
    endtask

    task automatic test_branch();
        step_t s[$];
        exp_t  e;
        logic [97:0] obs;
        s.push_back(mk(0, 0, 0, 0, 0, 0,            1, 32'h1c00_000c, "seq_0c"));
        s.push_back(mk(0, 0, 0, 0, 0, 0,            1, 32'h1c00_0010, "seq_10"));
        s.push_back(mk(0, 0, 0, 0, 1, 32'h1c00_0100, 1, 32'h1c00_0100, "br_target"));
        s.push_back(mk(0, 0, 0, 0, 0, 0,            1, 32'h1c00_0104, "br_plus4"));
        foreach (s[i]) begin
            drive_step(s[i]);
            tick();
            e = sb.pop_front();
            obs = observe();
            checks++;
            if (obs !== e.val) begin
                failures++;
                $display("FAIL %s got=%h exp=%h", e.nm, obs, e.val);
            end
        end
    endtask

    task automatic test_branch_under_stall();
        step_t s[$];
        exp_t  e;
        logic [97:0] obs;
        s.push_back(mk(0, 0, 0, 0, 1, 32'h1c00_0020, 1, 32'h1c00_0020, "to_0020"));
        s.push_back(mk(0, 0, 0, 1, 1, 32'h1c00_0200, 1, 32'h1c00_0020, "stall_hold1"));
        s.push_back(mk(0, 0, 0, 1, 1, 32'h1c00_0300, 1, 32'h1c00_0020, "stall_hold2"));
        s.push_back(mk(0, 0, 0, 1, 0, 0,            1, 32'h1c00_0020, "stall_hold3"));
        s.push_back(mk(0, 0, 0, 0, 0, 0,            1, 32'h1c00_0300, "pend_applied"));
        s.push_back(mk(0, 0, 0, 0, 0, 0,            1, 32'h1c00_0304, "pend_plus4"));
        foreach (s[i]) begin
            drive_step(s[i]);
            tick();
            e = sb.pop_front();
            obs = observe();
            checks++;
            if (obs !== e.val) begin
                failures++;
                $display("FAIL %s got=%h exp=%h", e.nm, obs, e.val);
            end
        end
    endtask

    task automatic test_flush_vs_branch();
        step_t s[$];
        exp_t  e;
        logic [97:0] obs;
        s.push_back(mk(0, 1, 32'h1c00_8000, 1, 1, 32'h1c00_0400, 1, 32'h1c00_8000, "flush_wins"));
        s.push_back(mk(0, 0, 0,             1, 0, 0,             1, 32'h1c00_8000, "flush_hold"));
        s.push_back(mk(0, 0, 0,             0, 0, 0,             1, 32'h1c00_8004, "no_stale_br"));
        s.push_back(mk(0, 0, 0,             0, 0, 0,             1, 32'h1c00_8008, "flush_seq"));
        foreach (s[i]) begin
            drive_step(s[i]);
            tick();
            e = sb.pop_front();
            obs = observe();
            checks++;
            if (obs !== e.val) begin
                failures++;
                $display("FAIL %s got=%h exp=%h", e.nm, obs, e.val);
            end
        end
    endtask

    task automatic test_misaligned();
        step_t s[$];
        exp_t  e;
        logic [97:0] obs;
        s.push_back(mk(0, 0, 0,             0, 1, 32'h1c00_0102, 1, 32'h1c00_0102, "adef_set"));
        s.push_back(mk(0, 0, 0,             0, 0, 0,             1, 32'h1c00_0106, "adef_advance"));
        s.push_back(mk(0, 1, 32'h1c00_1000, 0, 0, 0,             1, 32'h1c00_1000, "adef_cleared"));
        s.push_back(mk(0, 0, 0,             0, 0, 0,             1, 32'h1c00_1004, "after_adef"));
        foreach (s[i]) begin
            drive_step(s[i]);
            tick();
            e = sb.pop_front();
            obs = observe();
            checks++;
            if (obs !== e.val) begin
                failures++;
                $display("FAIL %s got=%h exp=%h", e.nm, obs, e.val);
            end
        end
    endtask

    task automatic test_wrap_and_reset();
        step_t s[$];
        exp_t  e;
        logic [97:0] obs;
        s.push_back(mk(0, 0, 0, 0, 1, 32'hffff_fffc, 1, 32'hffff_fffc, "to_top"));
        s.push_back(mk(0, 0, 0, 0, 0, 0,             1, 32'h0000_0000, "wrap_zero"));
        s.push_back(mk(0, 0, 0, 1, 1, 32'h1c00_0500, 1, 32'h0000_0000, "pend_set"));
        s.push_back(mk(1, 0, 0, 1, 0, 0,             0, RST_PC,        "midrun_reset"));
        s.push_back(mk(0, 0, 0, 0, 0, 0,             1, RST_PC,        "refetch_reset_pc"));
        s.push_back(mk(0, 0, 0, 0, 0, 0,             1, 32'h1c00_0004, "pend_discarded"));
        foreach (s[i]) begin
            drive_step(s[i]);
            tick();
            e = sb.pop_front();
            obs = observe();
            checks++;
            if (obs !== e.val) begin
                failures++;
                $display("FAIL %s got=%h exp=%h", e.nm, obs, e.val);
            end
        end
    endtask

    task automatic test_boot_flush();
        step_t s[$];
        exp_t  e;
        logic [97:0] obs;
        s.push_back(mk(1, 0, 0,             0, 0, 0, 0, RST_PC,        "boot_reset"));
        s.push_back(mk(0, 1, 32'h1c00_2000, 1, 0, 0, 1, 32'h1c00_2000, "boot_flush_stalled"));
        s.push_back(mk(0, 0, 0,             1, 0, 0, 1, 32'h1c00_2000, "boot_flush_hold"));
        s.push_back(mk(0, 0, 0,             0, 0, 0, 1, 32'h1c00_2004, "boot_flush_seq"));
        foreach (s[i]) begin
            drive_step(s[i]);
            tick();
            e = sb.pop_front();
            obs = observe();
            checks++;
            if (obs !== e.val) begin
                failures++;
                $display("FAIL %s got=%h exp=%h", e.nm, obs, e.val);
            end
        end
    endtask

    initial begin
        reset     = 1'b1;
        flush     = 1'b0;
        new_pc    = '0;
        stall     = '0;
        br_taken  = 1'b0;
        br_target = '0;
        #1;
        test_reset();
        test_branch();
        test_branch_under_stall();
        test_flush_vs_branch();
        test_misaligned();
        test_wrap_and_reset();
        test_boot_flush();
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain got=%0d exp=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
